// File: rtl/f5_sweep_pkg.sv
// f5_pkg: shared state encoding and constants for the f5_sweep truth-table sequencer
package f5_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;
    localparam logic [3:0] F5_EXPECT_IMPL = 4'b1011;
    localparam int F5_CNT_W = 4;
endpackage

// File: rtl/f5_settle_timer.sv
// f5_settle_timer: loadable down-counter that holds at zero and flags it
module f5_settle_timer import f5_pkg::*; (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [F5_CNT_W-1:0] value,
    output logic                zero
);
    logic [F5_CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (load) cnt <= value;
        else if (!zero) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/f5_sweep.sv
// f5_sweep: drives a two-input gate through minterms 0..3 and checks s against EXPECT.
// Define F5_SWEEP_FIRSTFAIL_EN to add the first-mismatch capture outputs fail_v/fail_m.
module f5_sweep import f5_pkg::*; #(
    parameter int         SETTLE = 1,
    parameter logic [3:0] EXPECT = F5_EXPECT_IMPL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       s,
    output logic       a,
    output logic       b,
    output logic [1:0] m,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] ok_mask,
    output logic [2:0] err_count
`ifdef F5_SWEEP_FIRSTFAIL_EN
    ,
    output logic       fail_v,
    output logic [1:0] fail_m
`endif
);
    state_t state;
    logic accept, load, zero, hit;
    logic [F5_CNT_W-1:0] reload;
    assign accept = state == IDLE && start;
    assign load   = accept || state == SAMPLE;
    assign reload = F5_CNT_W'(SETTLE - 1);
    assign hit    = s == EXPECT[m];
    f5_settle_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (reload),
        .zero  (zero)
    );
    // pass is formed on the last SAMPLE edge so it is valid together with done
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            a         <= 1'b0;
            b         <= 1'b0;
            m         <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            ok_mask   <= 4'd0;
            err_count <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= DRIVE;
                    {a, b}    <= 2'b00;
                    m         <= 2'd0;
                    busy      <= 1'b1;
                    pass      <= 1'b0;
                    ok_mask   <= 4'd0;
                    err_count <= 3'd0;
                end
                DRIVE: if (zero) state <= SAMPLE;
                SAMPLE: begin
                    ok_mask[m] <= hit;
                    err_count  <= err_count + {2'b00, !hit};
                    if (m == 2'd3) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= &ok_mask[2:0] & hit;
                    end else begin
                        state  <= DRIVE;
                        m      <= m + 2'd1;
                        {a, b} <= m + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
`ifdef F5_SWEEP_FIRSTFAIL_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            fail_v <= 1'b0;
            fail_m <= 2'd0;
        end else if (accept) begin
            fail_v <= 1'b0;
            fail_m <= 2'd0;
        end else if (state == SAMPLE && !hit && !fail_v) begin
            fail_v <= 1'b1;
            fail_m <= m;
        end
`endif
endmodule

// File: tb/tb_f5_sweep.sv
// tb_f5_sweep: randomized self-checking bench for f5_sweep with a timeline-based reference model
module tb_f5_sweep;
    localparam logic [3:0] EXP = 4'b1011;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] start = 2'b00;
    logic [1:0] s, a, b, busy, done, pass;
    logic [1:0] m [2];
    logic [3:0] ok [2];
    logic [2:0] ec [2];
    int gsel [2];
    logic [3:0] tt [2];
    int checks = 0;
    int errors = 0;
`ifdef F5_SWEEP_FIRSTFAIL_EN
    logic [1:0] fv;
    logic [1:0] fm [2];
`endif
    always #5 clk = ~clk;

    f5_sweep #(.SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .start(start[0]), .s(s[0]), .a(a[0]), .b(b[0]), .m(m[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .ok_mask(ok[0]), .err_count(ec[0])
`ifdef F5_SWEEP_FIRSTFAIL_EN
        , .fail_v(fv[0]), .fail_m(fm[0])
`endif
    );
    f5_sweep #(.SETTLE(3)) u3 (
        .clk(clk), .reset(reset), .start(start[1]), .s(s[1]), .a(a[1]), .b(b[1]), .m(m[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .ok_mask(ok[1]), .err_count(ec[1])
`ifdef F5_SWEEP_FIRSTFAIL_EN
        , .fail_v(fv[1]), .fail_m(fm[1])
`endif
    );

    // gate variants: 0 ~a|b, 1 stuck-at-0, 2 ~a, 3 NOR-only ~a|b, else arbitrary truth table
    function automatic logic gate(int g, logic x, logic y, logic [3:0] t);
        case (g)
            0: return ~x | y;
            1: return 1'b0;
            2: return ~x;
            3: return ~(~(~(x | x) | y) | ~(~(x | x) | y));
            default: return t[{x, y}];
        endcase
    endfunction

    function automatic int st(int i);
        return i == 0 ? 1 : 3;
    endfunction

    always_comb begin
        s = 2'b00;
        for (int i = 0; i < 2; i++) s[i] = gate(gsel[i], a[i], b[i], tt[i]);
    end

    // Reference model: k counts edges since acceptance; minterm j is judged at edge (j+1)*(SETTLE+1)
    bit act [2];
    int k [2];
    logic [1:0] xm [2];
    logic [3:0] xok [2];
    logic [2:0] xerr [2];
    logic xbusy [2], xdone [2], xpass [2], xfv [2];
    logic [1:0] xfm [2];
    always @(posedge clk or posedge reset)
        for (int i = 0; i < 2; i++) begin
            automatic int per = st(i) + 1;
            automatic int kn = k[i] + 1;
            automatic int j = kn / per - 1;
            automatic logic [1:0] jj = 2'(j);
            automatic logic r = gate(gsel[i], jj[1], jj[0], tt[i]) == EXP[jj];
            if (reset) begin
                act[i] <= 1'b0; k[i] <= 0; xm[i] <= 2'd0; xok[i] <= 4'd0; xerr[i] <= 3'd0;
                xbusy[i] <= 1'b0; xdone[i] <= 1'b0; xpass[i] <= 1'b0; xfv[i] <= 1'b0; xfm[i] <= 2'd0;
            end else if (!act[i]) begin
                xdone[i] <= 1'b0;
                if (start[i]) begin
                    act[i] <= 1'b1; k[i] <= 0; xm[i] <= 2'd0; xok[i] <= 4'd0; xerr[i] <= 3'd0;
                    xbusy[i] <= 1'b1; xpass[i] <= 1'b0; xfv[i] <= 1'b0; xfm[i] <= 2'd0;
                end
            end else begin
                k[i] <= kn;
                if (kn == 4 * per + 1) begin
                    act[i] <= 1'b0; xbusy[i] <= 1'b0; xdone[i] <= 1'b0;
                end else if (kn % per == 0) begin
                    xok[i][jj] <= r;
                    xerr[i] <= xerr[i] + 3'(!r);
                    if (!r && !xfv[i]) begin
                        xfv[i] <= 1'b1; xfm[i] <= jj;
                    end
                    if (jj == 2'd3) begin
                        xdone[i] <= 1'b1; xpass[i] <= xok[i][2:0] == 3'b111 && r;
                    end else xm[i] <= jj + 2'd1;
                end
            end
        end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [14:0] outs(int i);
        return {a[i], b[i], m[i], busy[i], done[i], pass[i], ok[i], ec[i]};
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset)
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("model_u%0d", i), 32'(outs(i)),
                        32'({xm[i], xm[i], xbusy[i], xdone[i], xpass[i], xok[i], xerr[i]}));
`ifdef F5_SWEEP_FIRSTFAIL_EN
                    chk($sformatf("model_fail_u%0d", i), 32'({fv[i], fm[i]}), 32'({xfv[i], xfm[i]}));
`endif
                end
        end
    endtask

    // Runs one sweep on instance i; poke re-pulses start, abort_at asserts reset mid-sweep
    task automatic sweep(input int i, input int g, input int poke, input int abort_at,
                         output int lat, output logic [7:0] seq);
        gsel[i] = g;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        chk("accept_busy_pass", {busy[i], pass[i]}, 2'b10);
        lat = 1;
        seq = {6'd0, a[i], b[i]};
        while (!done[i] && lat < 64) begin
            if (lat == abort_at) begin
                reset = 1'b1; #1;
                chk("reset_async", 32'(outs(i)), 0);
                @(negedge clk);
                reset = 1'b0;
                @(posedge clk); #1;
                return;
            end
            start[i] = lat == poke;
            @(posedge clk); #1;
            lat++;
            if ({a[i], b[i]} != seq[1:0]) seq = {seq[5:0], a[i], b[i]};
        end
        start[i] = 1'b0;
        chk("done_seen", done[i], 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        logic [7:0] seq;
        gsel[0] = 0; gsel[1] = 0; tt[0] = 4'd0; tt[1] = 4'd0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_u1", 32'(outs(0)), 0);
        chk("reset_u3", 32'(outs(1)), 0);
        @(posedge clk); #1;

        sweep(0, 0, 0, 0, lat, seq);
        chk("good_lat", lat, 9);
        chk("good_seq", seq, 8'h1B);
        chk("good_res", {pass[0], ok[0], ec[0]}, {1'b1, 4'b1111, 3'd0});

        sweep(0, 1, 0, 0, lat, seq);
        chk("stuck0_res", {pass[0], ok[0], ec[0]}, {1'b0, 4'b0100, 3'd3});
`ifdef F5_SWEEP_FIRSTFAIL_EN
        chk("stuck0_fail", {fv[0], fm[0]}, 3'b100);
`endif

        sweep(0, 0, 3, 0, lat, seq);
        chk("busy_start_lat", lat, 9);
        chk("busy_start_res", {pass[0], ok[0], ec[0]}, {1'b1, 4'b1111, 3'd0});

        sweep(0, 0, 0, 6, lat, seq);
        sweep(0, 0, 0, 0, lat, seq);
        chk("post_reset_lat", lat, 9);
        chk("post_reset_res", {pass[0], ok[0], ec[0]}, {1'b1, 4'b1111, 3'd0});

        sweep(1, 3, 0, 0, lat, seq);
        chk("nor_lat", lat, 17);
        chk("nor_seq", seq, 8'h1B);
        chk("nor_pass", pass[1], 1'b1);

        sweep(1, 2, 0, 0, lat, seq);
        chk("b2b_res", {pass[1], ok[1], ec[1]}, {1'b0, 4'b0111, 3'd1});

        for (int n = 0; n < 16; n++) begin
            automatic int i = $urandom_range(0, 1);
            automatic logic [3:0] diff;
            tt[i] = 4'($urandom);
            diff = tt[i] ^ EXP;
            sweep(i, 4, $urandom_range(0, 12), 0, lat, seq);
            chk("rand_lat", lat, 4 * (st(i) + 1) + 1);
            chk("rand_res", {pass[i], ok[i], ec[i]}, {diff == 4'd0, ~diff, 3'($countones(diff))});
`ifdef F5_SWEEP_FIRSTFAIL_EN
            begin
                automatic logic [1:0] first = 2'd0;
                for (int q = 3; q >= 0; q--) if (diff[q]) first = 2'(q);
                chk("rand_fail", {fv[i], fm[i]}, {diff != 4'd0, first});
            end
`endif
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
